// File: rtl/mc_pkg.sv
// Shared multicycle-core definitions: next-PC select encodings, instruction
// field positions, datapath width and the jump-target helper.
package mc_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned JADDR_MSB = 25;

  // Next-PC source select driven by the main decoder
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_e;

  // Pseudo-direct jump target: upper PC nibble, 26-bit word index, byte offset 0
  function automatic logic [WORD_W-1:0] jump_target(input logic [WORD_W-1:0] pc,
                                                    input logic [WORD_W-1:0] instr);
    return {pc[WORD_W-1:WORD_W-4], instr[JADDR_MSB:0], 2'b00};
  endfunction

endpackage : mc_pkg

// File: rtl/pc_ir_unit_flopenr.sv
// flopenr: enabled register with asynchronous active-low clear to RESET_VAL.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low clear
//   en_i   - load enable
//   d_i    - next value
//   q_o    - registered value
module flopenr #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= RESET_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule : flopenr

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: multicycle PC / instruction-register stage. Holds PC, IR, the
// memory data register, ALUOut and a fetched-instruction counter, and muxes
// the memory address between PC and ALUOut.
// Optional feature: define PCIR_MISALIGN_TRAP_EN to block misaligned PC
// writes and expose the sticky MisAlign flag.
// Ports:
//   CLK, RESET          - clock, asynchronous active-low reset
//   PCWr, Brnch, Zero   - PC write strobes (PCEn = PCWr | Brnch & Zero)
//   PCSr                - next-PC select (ALUResult / ALUOut / jump / reserved)
//   IRWr                - instruction register load
//   IrD                 - memory address select (0 = PC, 1 = ALUOut)
//   ALUResult, MemRdData- datapath inputs
//   PC, Instr, Data, ALUOut, InstrCount - registered state
//   op, funct, MemAdr   - combinational views of the state
//   MisAlign            - sticky misaligned-PC flag (trap build only)
module pc_ir_unit
  import mc_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PCWr,
  input  logic             Brnch,
  input  logic             Zero,
  input  logic [1:0]       PCSr,
  input  logic             IRWr,
  input  logic             IrD,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] MemRdData,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] Instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [WIDTH-1:0] Data,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] MemAdr,
  output logic [31:0]      InstrCount
`ifdef PCIR_MISALIGN_TRAP_EN
  ,
  output logic             MisAlign
`endif
);

  logic             pc_en_c;
  logic             pc_sel_ok_c;
  logic             pc_load_c;
  logic [WIDTH-1:0] pc_d;
  logic [31:0]      cnt_d;
  pcsrc_e           pcsrc_c;

  assign pcsrc_c = pcsrc_e'(PCSr);
  assign pc_en_c = PCWr | (Brnch & Zero);

  // Next-PC mux; the reserved select leaves the PC untouched
  always_comb begin
    pc_d        = PC;
    pc_sel_ok_c = 1'b1;
    case (pcsrc_c)
      PCSRC_ALU:    pc_d = ALUResult;
      PCSRC_ALUOUT: pc_d = ALUOut;
      PCSRC_JUMP:   pc_d = WIDTH'(jump_target(WORD_W'(PC), WORD_W'(Instr)));
      default:      pc_sel_ok_c = 1'b0;
    endcase
  end

`ifdef PCIR_MISALIGN_TRAP_EN
  logic misalign_q;
  logic misalign_d;
  logic pc_misal_c;

  // A misaligned target suppresses the write and freezes the PC until reset
  assign pc_misal_c = |pc_d[1:0];
  assign pc_load_c  = pc_en_c & pc_sel_ok_c & ~pc_misal_c & ~misalign_q;
  assign misalign_d = misalign_q | (pc_en_c & pc_sel_ok_c & pc_misal_c);

  flopenr #(.WIDTH(1), .RESET_VAL(1'b0)) u_misalign (
    .clk   (CLK),
    .rst_n (RESET),
    .en_i  (1'b1),
    .d_i   (misalign_d),
    .q_o   (misalign_q)
  );

  assign MisAlign = misalign_q;
`else
  assign pc_load_c = pc_en_c & pc_sel_ok_c;
`endif

  flopenr #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
    .clk   (CLK),
    .rst_n (RESET),
    .en_i  (pc_load_c),
    .d_i   (pc_d),
    .q_o   (PC)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
    .clk   (CLK),
    .rst_n (RESET),
    .en_i  (IRWr),
    .d_i   (MemRdData),
    .q_o   (Instr)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_data (
    .clk   (CLK),
    .rst_n (RESET),
    .en_i  (1'b1),
    .d_i   (MemRdData),
    .q_o   (Data)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_aluout (
    .clk   (CLK),
    .rst_n (RESET),
    .en_i  (1'b1),
    .d_i   (ALUResult),
    .q_o   (ALUOut)
  );

  // Fetch counter wraps naturally at 2^32
  assign cnt_d = InstrCount + 32'd1;

  flopenr #(.WIDTH(32), .RESET_VAL(32'd0)) u_cnt (
    .clk   (CLK),
    .rst_n (RESET),
    .en_i  (IRWr),
    .d_i   (cnt_d),
    .q_o   (InstrCount)
  );

  assign op     = Instr[OP_MSB:OP_LSB];
  assign funct  = Instr[FUNCT_MSB:FUNCT_LSB];
  assign MemAdr = IrD ? ALUOut : PC;

endmodule : pc_ir_unit

// File: doc/pc_ir_unit.md
# pc_ir_unit

Multicycle program-counter and instruction-register stage. Holds PC, IR, memory data register and ALUOut, and muxes the memory address. It consumes the main decoder's `PCWr`, `Brnch`, `PCSr`, `IRWr` and `IrD` strobes. It feeds the decoder its `op` field from the registered instruction, closing the fetch/decode loop of the multicycle core.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; must be 32 (jump-target math is fixed).
- `RESET_PC`, 32'h0000_0000, PC value after reset; must be word-aligned.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RESET`  in  1  reset, asynchronous, active-low.
- `PCWr`  in  1  unconditional PC write (decoder).
- `Brnch`  in  1  conditional PC write (decoder).
- `Zero`  in  1  ALU zero flag, same cycle as `Brnch`.
- `PCSr`  in  2  next-PC select (decoder).
- `IRWr`  in  1  instruction-register load (decoder).
- `IrD`  in  1  memory address select: 0 = PC, 1 = ALUOut.
- `ALUResult`  in  WIDTH  combinational ALU output.
- `MemRdData`  in  WIDTH  memory read data.
- `PC`  out  WIDTH  program counter.
- `Instr`  out  WIDTH  instruction register.
- `op`  out  6  `Instr[31:26]`, to decoder.
- `funct`  out  6  `Instr[5:0]`, to ALU decoder.
- `Data`  out  WIDTH  memory data register.
- `ALUOut`  out  WIDTH  ALU result register.
- `MemAdr`  out  WIDTH  memory address.
- `InstrCount`  out  32  count of instructions fetched.
- `MisAlign`  out  1  sticky misaligned-PC flag; present only with the macro defined.

## Operation
- PC enable: `PCEn = PCWr | (Brnch & Zero)`.
- Next PC by `PCSr`:
  - 00: `ALUResult`.
  - 01: `ALUOut`.
  - 10: `{PC[31:28], Instr[25:0], 2'b00}`, using the current registered PC and Instr.
  - 11: reserved; PC holds even if `PCEn`=1.
- `Instr` loads `MemRdData` when `IRWr`=1; otherwise holds.
- `Data` loads `MemRdData` every cycle.
- `ALUOut` loads `ALUResult` every cycle.
- `MemAdr = IrD ? ALUOut : PC`. This path is combinational; no registers.
- `op` and `funct` are combinational slices of `Instr`.
- `InstrCount` increments by 1 on every cycle with `IRWr`=1. It wraps from 2^32-1 to 0.
- Fetch cycle (`IRWr`=`PCWr`=1, `PCSr`=00):
  - IR captures the word at the old PC.
  - PC takes `ALUResult` (PC+4).
  - Both updates happen at the same edge.

## Timing
- Reset (`RESET`=0, asynchronous) forces:
  - `PC`=`RESET_PC`.
  - `Instr`, `Data`, `ALUOut`, `InstrCount` = 0.
  - `MisAlign`=0.
  - Consequently `op`=0 and `funct`=0.
- Reset release is sampled at the rising edge. The first update occurs at the first rising edge with `RESET`=1.
- Reset mid-instruction: all state clears immediately. No partial update survives. The decoder restarts fetch from `RESET_PC`.
- All register latency is 1 cycle. `MemAdr`, `op` and `funct` have 0-cycle latency from their sources.
- Simultaneous `PCWr`=1 and `Brnch`=1 with `Zero`=0: PC still writes, since `PCWr` dominates.
- `Brnch`=1 with `Zero`=X is not a legal input; the bench never drives it.

## Configuration
- `PCIR_MISALIGN_TRAP_EN` defined:
  - If `PCEn`=1 and the selected next PC has bits [1:0]≠0, the PC write is suppressed and PC holds.
  - `MisAlign` sets and stays 1 until reset.
  - Once `MisAlign`=1, all further PC writes are blocked.
- `PCIR_MISALIGN_TRAP_EN` not defined:
  - No `MisAlign` port.
  - PC loads any value unchecked.

## Structure
- Shared package `mc_pkg`:
  - `PCSr` encodings: `PCSRC_ALU`=2'b00, `PCSRC_ALUOUT`=2'b01, `PCSRC_JUMP`=2'b10.
  - Field positions `OP_MSB`/`OP_LSB`.
  - `WORD_W`=32.
- One sub-module, `flopenr`: parameterized-width enabled register with asynchronous active-low clear and a reset-value parameter. It is used for PC, IR and the counter. `Data` and `ALUOut` tie enable to 1.

## Test plan
- Reset, then release; `MemRdData`=32'h8C01_0004, `IRWr`=`PCWr`=1, `PCSr`=00, `ALUResult`=4:
  - After one edge: `Instr`=32'h8C01_0004, `op`=6'h23, `PC`=4, `InstrCount`=1.
- `Brnch`=1, `Zero`=0, `PCSr`=01, `ALUOut`=32'h40 → PC unchanged.
- Same with `Zero`=1 → `PC`=32'h40.
- `PC`=32'hA000_0010, `Instr[25:0]`=26'h0000100, `PCSr`=10, `PCWr`=1 → `PC`=32'hA000_0400.
- `IrD`=1, `ALUOut`=32'h1234 → `MemAdr`=32'h1234 in the same cycle. `IrD`=0 → `MemAdr`=`PC`.
- Assert `RESET`=0 mid-cycle after 5 fetches:
  - Immediately: `PC`=`RESET_PC`, `InstrCount`=0.
  - With the macro defined, `ALUResult`=6 on a fetch: PC holds and `MisAlign`=1 until reset.
